// File: rtl/axi_riscv_lrsc_pkg.sv
// LR/SC initiator shared types: op enum, FSM states, AXI resp codes.
// Ports: none (package).
package axi_riscv_lrsc_pkg;

  typedef enum logic {
    OP_LR = 1'b0,
    OP_SC = 1'b1
  } lrsc_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_RSP
  } lrsc_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // {success, err}; both error codes have bit 1 set
  function automatic logic [1:0] resp_decode(
    input logic [1:0] resp
  );
    return {resp == RESP_EXOKAY, resp[1]};
  endfunction

endpackage

// File: rtl/axi_riscv_lrsc_bus_if.sv
// AXI4+ATOP bus bundle with Master/Slave modports.
// Ports: none; signals aw/w/b/ar/r channel fields.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 0,
  parameter int unsigned AXI_DATA_WIDTH = 0,
  parameter int unsigned AXI_ID_WIDTH   = 0,
  parameter int unsigned AXI_USER_WIDTH = 0
);
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_region;
  logic [5:0]                  aw_atop;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [3:0]                  aw_qos;
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_last;
  logic                        w_valid;
  logic                        w_ready;
  logic [1:0]                  b_resp;
  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_region;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [3:0]                  ar_qos;
  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_region, aw_atop, aw_len, aw_size,
    output aw_burst, aw_lock, aw_cache, aw_qos, aw_id, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_user, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_id, b_user, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_region, ar_len, ar_size,
    output ar_burst, ar_lock, ar_cache, ar_qos, ar_id, ar_user, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_id, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_region, aw_atop, aw_len, aw_size,
    input  aw_burst, aw_lock, aw_cache, aw_qos, aw_id, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_user, w_last, w_valid,
    output w_ready,
    output b_resp, b_id, b_user, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_region, ar_len, ar_size,
    input  ar_burst, ar_lock, ar_cache, ar_qos, ar_id, ar_user, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_id, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_riscv_lrsc_initiator_wrap.sv
// Wrapper exposing the LR/SC initiator master side as an AXI_BUS.
// Ports: clk_i, rst_ni, req_*, rsp_*, mst (AXI_BUS.Master).
module axi_riscv_lrsc_initiator_wrap #(
  parameter int unsigned AXI_ADDR_WIDTH = 0,
  parameter int unsigned AXI_DATA_WIDTH = 0,
  parameter int unsigned AXI_ID_WIDTH   = 0,
  parameter int unsigned AXI_USER_WIDTH = 0,
  parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_sc_i,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_success_o,
  output logic                      rsp_err_o,
  AXI_BUS.Master                    mst
);

  axi_riscv_lrsc_initiator #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .AXI_ID_WIDTH   (AXI_ID_WIDTH),
    .AXI_USER_WIDTH (AXI_USER_WIDTH),
    .TXN_ID         (TXN_ID)
  ) u_core (
    .clk_i, .rst_ni,
    .req_valid_i, .req_ready_o, .req_sc_i, .req_addr_i, .req_wdata_i,
    .rsp_valid_o, .rsp_ready_i, .rsp_rdata_o, .rsp_success_o, .rsp_err_o,
    .mst_aw_addr_o   (mst.aw_addr),
    .mst_aw_prot_o   (mst.aw_prot),
    .mst_aw_region_o (mst.aw_region),
    .mst_aw_atop_o   (mst.aw_atop),
    .mst_aw_len_o    (mst.aw_len),
    .mst_aw_size_o   (mst.aw_size),
    .mst_aw_burst_o  (mst.aw_burst),
    .mst_aw_lock_o   (mst.aw_lock),
    .mst_aw_cache_o  (mst.aw_cache),
    .mst_aw_qos_o    (mst.aw_qos),
    .mst_aw_id_o     (mst.aw_id),
    .mst_aw_user_o   (mst.aw_user),
    .mst_aw_valid_o  (mst.aw_valid),
    .mst_aw_ready_i  (mst.aw_ready),
    .mst_w_data_o    (mst.w_data),
    .mst_w_strb_o    (mst.w_strb),
    .mst_w_user_o    (mst.w_user),
    .mst_w_last_o    (mst.w_last),
    .mst_w_valid_o   (mst.w_valid),
    .mst_w_ready_i   (mst.w_ready),
    .mst_b_resp_i    (mst.b_resp),
    .mst_b_id_i      (mst.b_id),
    .mst_b_user_i    (mst.b_user),
    .mst_b_valid_i   (mst.b_valid),
    .mst_b_ready_o   (mst.b_ready),
    .mst_ar_addr_o   (mst.ar_addr),
    .mst_ar_prot_o   (mst.ar_prot),
    .mst_ar_region_o (mst.ar_region),
    .mst_ar_len_o    (mst.ar_len),
    .mst_ar_size_o   (mst.ar_size),
    .mst_ar_burst_o  (mst.ar_burst),
    .mst_ar_lock_o   (mst.ar_lock),
    .mst_ar_cache_o  (mst.ar_cache),
    .mst_ar_qos_o    (mst.ar_qos),
    .mst_ar_id_o     (mst.ar_id),
    .mst_ar_user_o   (mst.ar_user),
    .mst_ar_valid_o  (mst.ar_valid),
    .mst_ar_ready_i  (mst.ar_ready),
    .mst_r_data_i    (mst.r_data),
    .mst_r_resp_i    (mst.r_resp),
    .mst_r_last_i    (mst.r_last),
    .mst_r_id_i      (mst.r_id),
    .mst_r_user_i    (mst.r_user),
    .mst_r_valid_i   (mst.r_valid),
    .mst_r_ready_o   (mst.r_ready)
  );

endmodule

// File: rtl/axi_riscv_lrsc_initiator.sv
// Single-outstanding LR/SC initiator: issues exclusive AXI read/write.
// Ports: req_* in, rsp_* out, mst_{aw,w,b,ar,r}_* AXI master side.
module axi_riscv_lrsc_initiator
  import axi_riscv_lrsc_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 0,
  parameter int unsigned AXI_DATA_WIDTH = 0,
  parameter int unsigned AXI_ID_WIDTH   = 0,
  parameter int unsigned AXI_USER_WIDTH = 0,
  parameter logic [AXI_ID_WIDTH-1:0] TXN_ID = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_sc_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                        rsp_success_o,
  output logic                        rsp_err_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mst_aw_addr_o,
  output logic [2:0]                  mst_aw_prot_o,
  output logic [3:0]                  mst_aw_region_o,
  output logic [5:0]                  mst_aw_atop_o,
  output logic [7:0]                  mst_aw_len_o,
  output logic [2:0]                  mst_aw_size_o,
  output logic [1:0]                  mst_aw_burst_o,
  output logic                        mst_aw_lock_o,
  output logic [3:0]                  mst_aw_cache_o,
  output logic [3:0]                  mst_aw_qos_o,
  output logic [AXI_ID_WIDTH-1:0]     mst_aw_id_o,
  output logic [AXI_USER_WIDTH-1:0]   mst_aw_user_o,
  output logic                        mst_aw_valid_o,
  input  logic                        mst_aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   mst_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mst_w_strb_o,
  output logic [AXI_USER_WIDTH-1:0]   mst_w_user_o,
  output logic                        mst_w_last_o,
  output logic                        mst_w_valid_o,
  input  logic                        mst_w_ready_i,
  input  logic [1:0]                  mst_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]     mst_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   mst_b_user_i,
  input  logic                        mst_b_valid_i,
  output logic                        mst_b_ready_o,
  output logic [AXI_ADDR_WIDTH-1:0]   mst_ar_addr_o,
  output logic [2:0]                  mst_ar_prot_o,
  output logic [3:0]                  mst_ar_region_o,
  output logic [7:0]                  mst_ar_len_o,
  output logic [2:0]                  mst_ar_size_o,
  output logic [1:0]                  mst_ar_burst_o,
  output logic                        mst_ar_lock_o,
  output logic [3:0]                  mst_ar_cache_o,
  output logic [3:0]                  mst_ar_qos_o,
  output logic [AXI_ID_WIDTH-1:0]     mst_ar_id_o,
  output logic [AXI_USER_WIDTH-1:0]   mst_ar_user_o,
  output logic                        mst_ar_valid_o,
  input  logic                        mst_ar_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   mst_r_data_i,
  input  logic [1:0]                  mst_r_resp_i,
  input  logic                        mst_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]     mst_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   mst_r_user_i,
  input  logic                        mst_r_valid_i,
  output logic                        mst_r_ready_o
);

  localparam logic [2:0] AxSize =
    3'($clog2(AXI_DATA_WIDTH / 8));

  lrsc_state_e               state_q;
  lrsc_op_e                  op_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      succ_q;
  logic                      err_q;
  logic                      aw_done_q;
  logic                      w_done_q;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      unused_inputs;

  assign req_ready_o   = state_q == ST_IDLE;
  assign rsp_valid_o   = state_q == ST_RSP;
  assign rsp_rdata_o   = (op_q == OP_LR) ? rdata_q : '0;
  assign rsp_success_o = succ_q;
  assign rsp_err_o     = err_q;

  assign mst_ar_valid_o = state_q == ST_AR;
  assign mst_r_ready_o  = state_q == ST_R;
  assign mst_b_ready_o  = state_q == ST_B;
  // AW and W retire independently inside AW_W
  assign mst_aw_valid_o = (state_q == ST_AW_W) && !aw_done_q;
  assign mst_w_valid_o  = (state_q == ST_AW_W) && !w_done_q;
  assign aw_hs = mst_aw_valid_o && mst_aw_ready_i;
  assign w_hs  = mst_w_valid_o && mst_w_ready_i;

  assign mst_aw_addr_o   = addr_q;
  assign mst_aw_prot_o   = '0;
  assign mst_aw_region_o = '0;
  assign mst_aw_atop_o   = '0;
  assign mst_aw_len_o    = '0;
  assign mst_aw_size_o   = AxSize;
  assign mst_aw_burst_o  = BURST_INCR;
  assign mst_aw_lock_o   = 1'b1;
  assign mst_aw_cache_o  = '0;
  assign mst_aw_qos_o    = '0;
  assign mst_aw_id_o     = TXN_ID;
  assign mst_aw_user_o   = '0;

  assign mst_w_data_o = wdata_q;
  assign mst_w_strb_o = '1;
  assign mst_w_user_o = '0;
  assign mst_w_last_o = 1'b1;

  assign mst_ar_addr_o   = addr_q;
  assign mst_ar_prot_o   = '0;
  assign mst_ar_region_o = '0;
  assign mst_ar_len_o    = '0;
  assign mst_ar_size_o   = AxSize;
  assign mst_ar_burst_o  = BURST_INCR;
  assign mst_ar_lock_o   = 1'b1;
  assign mst_ar_cache_o  = '0;
  assign mst_ar_qos_o    = '0;
  assign mst_ar_id_o     = TXN_ID;
  assign mst_ar_user_o   = '0;

  // IDs are only checked by the assertions below
  assign unused_inputs = ^{mst_b_id_i, mst_b_user_i,
                           mst_r_id_i, mst_r_user_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LR;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      succ_q    <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req_valid_i) begin
          op_q      <= lrsc_op_e'(req_sc_i);
          addr_q    <= req_addr_i;
          wdata_q   <= req_wdata_i;
          rdata_q   <= '0;
          succ_q    <= 1'b0;
          err_q     <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          state_q   <= req_sc_i ? ST_AW_W : ST_AR;
        end
        ST_AR: if (mst_ar_ready_i) state_q <= ST_R;
        ST_R: if (mst_r_valid_i && mst_r_last_i) begin
          rdata_q           <= mst_r_data_i;
          {succ_q, err_q}   <= resp_decode(mst_r_resp_i);
          state_q           <= ST_RSP;
        end
        ST_AW_W: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs) w_done_q <= 1'b1;
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
            state_q <= ST_B;
        end
        ST_B: if (mst_b_valid_i) begin
          {succ_q, err_q} <= resp_decode(mst_b_resp_i);
          state_q         <= ST_RSP;
        end
        ST_RSP: if (rsp_ready_i) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  r_id_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_r_valid_i && mst_r_ready_o) |-> mst_r_id_i == TXN_ID);
  b_id_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_b_valid_i && mst_b_ready_o) |-> mst_b_id_i == TXN_ID);

endmodule

// File: tb/tb_axi_riscv_lrsc_initiator.sv
// Directed bench for the LR/SC initiator with a small AXI slave model.
// Ports: none (top-level bench).
module tb_axi_riscv_lrsc_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int UW = 1;
  localparam logic [IW-1:0] TID = 4'd5;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_sc_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_success_o;
  logic          rsp_err_o;

  logic [AW-1:0] mst_aw_addr_o;
  logic [2:0]    mst_aw_prot_o;
  logic [3:0]    mst_aw_region_o;
  logic [5:0]    mst_aw_atop_o;
  logic [7:0]    mst_aw_len_o;
  logic [2:0]    mst_aw_size_o;
  logic [1:0]    mst_aw_burst_o;
  logic          mst_aw_lock_o;
  logic [3:0]    mst_aw_cache_o;
  logic [3:0]    mst_aw_qos_o;
  logic [IW-1:0] mst_aw_id_o;
  logic [UW-1:0] mst_aw_user_o;
  logic          mst_aw_valid_o;
  logic          mst_aw_ready_i = 1'b0;
  logic [DW-1:0] mst_w_data_o;
  logic [3:0]    mst_w_strb_o;
  logic [UW-1:0] mst_w_user_o;
  logic          mst_w_last_o;
  logic          mst_w_valid_o;
  logic          mst_w_ready_i = 1'b0;
  logic [1:0]    mst_b_resp_i = '0;
  logic [IW-1:0] mst_b_id_i = TID;
  logic [UW-1:0] mst_b_user_i = '0;
  logic          mst_b_valid_i = 1'b0;
  logic          mst_b_ready_o;
  logic [AW-1:0] mst_ar_addr_o;
  logic [2:0]    mst_ar_prot_o;
  logic [3:0]    mst_ar_region_o;
  logic [7:0]    mst_ar_len_o;
  logic [2:0]    mst_ar_size_o;
  logic [1:0]    mst_ar_burst_o;
  logic          mst_ar_lock_o;
  logic [3:0]    mst_ar_cache_o;
  logic [3:0]    mst_ar_qos_o;
  logic [IW-1:0] mst_ar_id_o;
  logic [UW-1:0] mst_ar_user_o;
  logic          mst_ar_valid_o;
  logic          mst_ar_ready_i = 1'b0;
  logic [DW-1:0] mst_r_data_i = '0;
  logic [1:0]    mst_r_resp_i = '0;
  logic          mst_r_last_i = 1'b0;
  logic [IW-1:0] mst_r_id_i = TID;
  logic [UW-1:0] mst_r_user_i = '0;
  logic          mst_r_valid_i = 1'b0;
  logic          mst_r_ready_o;

  axi_riscv_lrsc_initiator #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH   (IW),
    .AXI_USER_WIDTH (UW),
    .TXN_ID         (TID)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_sc_i        (req_sc_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_success_o   (rsp_success_o),
    .rsp_err_o       (rsp_err_o),
    .mst_aw_addr_o   (mst_aw_addr_o),
    .mst_aw_prot_o   (mst_aw_prot_o),
    .mst_aw_region_o (mst_aw_region_o),
    .mst_aw_atop_o   (mst_aw_atop_o),
    .mst_aw_len_o    (mst_aw_len_o),
    .mst_aw_size_o   (mst_aw_size_o),
    .mst_aw_burst_o  (mst_aw_burst_o),
    .mst_aw_lock_o   (mst_aw_lock_o),
    .mst_aw_cache_o  (mst_aw_cache_o),
    .mst_aw_qos_o    (mst_aw_qos_o),
    .mst_aw_id_o     (mst_aw_id_o),
    .mst_aw_user_o   (mst_aw_user_o),
    .mst_aw_valid_o  (mst_aw_valid_o),
    .mst_aw_ready_i  (mst_aw_ready_i),
    .mst_w_data_o    (mst_w_data_o),
    .mst_w_strb_o    (mst_w_strb_o),
    .mst_w_user_o    (mst_w_user_o),
    .mst_w_last_o    (mst_w_last_o),
    .mst_w_valid_o   (mst_w_valid_o),
    .mst_w_ready_i   (mst_w_ready_i),
    .mst_b_resp_i    (mst_b_resp_i),
    .mst_b_id_i      (mst_b_id_i),
    .mst_b_user_i    (mst_b_user_i),
    .mst_b_valid_i   (mst_b_valid_i),
    .mst_b_ready_o   (mst_b_ready_o),
    .mst_ar_addr_o   (mst_ar_addr_o),
    .mst_ar_prot_o   (mst_ar_prot_o),
    .mst_ar_region_o (mst_ar_region_o),
    .mst_ar_len_o    (mst_ar_len_o),
    .mst_ar_size_o   (mst_ar_size_o),
    .mst_ar_burst_o  (mst_ar_burst_o),
    .mst_ar_lock_o   (mst_ar_lock_o),
    .mst_ar_cache_o  (mst_ar_cache_o),
    .mst_ar_qos_o    (mst_ar_qos_o),
    .mst_ar_id_o     (mst_ar_id_o),
    .mst_ar_user_o   (mst_ar_user_o),
    .mst_ar_valid_o  (mst_ar_valid_o),
    .mst_ar_ready_i  (mst_ar_ready_i),
    .mst_r_data_i    (mst_r_data_i),
    .mst_r_resp_i    (mst_r_resp_i),
    .mst_r_last_i    (mst_r_last_i),
    .mst_r_id_i      (mst_r_id_i),
    .mst_r_user_i    (mst_r_user_i),
    .mst_r_valid_i   (mst_r_valid_i),
    .mst_r_ready_o   (mst_r_ready_o)
  );

  // Idle wrapper instance keeps the interface variant elaborated
  AXI_BUS #(
    .AXI_ADDR_WIDTH (AW), .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH (IW), .AXI_USER_WIDTH (UW)
  ) wbus ();
  assign wbus.aw_ready = 1'b0;
  assign wbus.w_ready  = 1'b0;
  assign wbus.b_resp   = '0;
  assign wbus.b_id     = '0;
  assign wbus.b_user   = '0;
  assign wbus.b_valid  = 1'b0;
  assign wbus.ar_ready = 1'b0;
  assign wbus.r_data   = '0;
  assign wbus.r_resp   = '0;
  assign wbus.r_last   = 1'b0;
  assign wbus.r_id     = '0;
  assign wbus.r_user   = '0;
  assign wbus.r_valid  = 1'b0;
  logic          w_req_ready, w_rsp_valid, w_rsp_succ, w_rsp_err;
  logic [DW-1:0] w_rsp_rdata;

  axi_riscv_lrsc_initiator_wrap #(
    .AXI_ADDR_WIDTH (AW), .AXI_DATA_WIDTH (DW),
    .AXI_ID_WIDTH (IW), .AXI_USER_WIDTH (UW), .TXN_ID (TID)
  ) u_wrap (
    .clk_i (clk_i), .rst_ni (rst_ni),
    .req_valid_i (1'b0), .req_ready_o (w_req_ready),
    .req_sc_i (1'b0), .req_addr_i ('0), .req_wdata_i ('0),
    .rsp_valid_o (w_rsp_valid), .rsp_ready_i (1'b0),
    .rsp_rdata_o (w_rsp_rdata), .rsp_success_o (w_rsp_succ),
    .rsp_err_o (w_rsp_err), .mst (wbus)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          succ;
    logic          err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // slave configuration
  logic [DW-1:0] cfg_rdata = '0;
  logic [1:0]    cfg_resp = 2'b00;
  int            cfg_aw_delay = 0;
  logic          r_stall = 1'b0;
  int            aw_wait = 0;

  // monitor state
  logic          r_pend = 1'b0, b_pend = 1'b0;
  logic          aw_got = 1'b0, w_got = 1'b0;
  int            ar_cnt = 0, aw_cnt = 0, w_cnt = 0, aw_unstable = 0;
  logic [AW-1:0] ar_addr_s = '0, aw_addr_s = '0;
  logic [7:0]    ar_len_s = '1;
  logic [2:0]    ar_size_s = '0;
  logic [1:0]    ar_burst_s = '0;
  logic [IW-1:0] ar_id_s = '0;
  logic          ar_lock_s = 1'b0, aw_lock_s = 1'b0;
  logic [3:0]    w_strb_s = '0;
  logic          w_last_s = 1'b0;
  logic [DW-1:0] w_data_s = '0;
  logic          aw_v_prev = 1'b0, aw_r_prev = 1'b0;
  logic [AW-1:0] aw_a_prev = '0;

  always @(posedge clk_i) begin
    logic awh, wh;
    awh = mst_aw_valid_o && mst_aw_ready_i;
    wh  = mst_w_valid_o && mst_w_ready_i;
    if (!rst_ni) begin
      r_pend <= 1'b0; b_pend <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_v_prev <= 1'b0;
    end else begin
      if (mst_ar_valid_o && mst_ar_ready_i) begin
        ar_cnt <= ar_cnt + 1; r_pend <= 1'b1;
        ar_addr_s <= mst_ar_addr_o; ar_len_s <= mst_ar_len_o;
        ar_size_s <= mst_ar_size_o; ar_burst_s <= mst_ar_burst_o;
        ar_id_s <= mst_ar_id_o; ar_lock_s <= mst_ar_lock_o;
      end
      if (mst_r_valid_i && mst_r_ready_o) r_pend <= 1'b0;
      if (awh) begin
        aw_cnt <= aw_cnt + 1;
        aw_addr_s <= mst_aw_addr_o; aw_lock_s <= mst_aw_lock_o;
      end
      if (wh) begin
        w_cnt <= w_cnt + 1;
        w_strb_s <= mst_w_strb_o; w_last_s <= mst_w_last_o;
        w_data_s <= mst_w_data_o;
      end
      if ((aw_got || awh) && (w_got || wh)) begin
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (awh) aw_got <= 1'b1;
        if (wh) w_got <= 1'b1;
      end
      if (mst_b_valid_i && mst_b_ready_o) b_pend <= 1'b0;
      if (aw_v_prev && !aw_r_prev &&
          (!mst_aw_valid_o || mst_aw_addr_o != aw_a_prev))
        aw_unstable <= aw_unstable + 1;
      aw_v_prev <= mst_aw_valid_o;
      aw_r_prev <= mst_aw_ready_i;
      aw_a_prev <= mst_aw_addr_o;
    end
  end

  // slave drives its channel inputs away from the active edge
  always @(negedge clk_i) begin
    mst_r_valid_i  = r_pend && !r_stall;
    mst_r_data_i   = cfg_rdata;
    mst_r_resp_i   = cfg_resp;
    mst_r_last_i   = 1'b1;
    mst_b_valid_i  = b_pend;
    mst_b_resp_i   = cfg_resp;
    mst_ar_ready_i = 1'b1;
    mst_w_ready_i  = 1'b1;
    if (mst_aw_valid_o) begin
      mst_aw_ready_i = (aw_wait >= cfg_aw_delay);
      aw_wait++;
    end else begin
      mst_aw_ready_i = 1'b0;
      aw_wait = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic sc, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd, input int exp_lat,
                     input int hold, input string tag);
    exp_t e;
    int lat;
    e.rdata = sc ? '0 : cfg_rdata;
    e.succ  = (cfg_resp == 2'b01);
    e.err   = cfg_resp[1];
    sb.push_back(e);
    @(negedge clk_i);
    chk({tag, " req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_sc_i = sc;
    req_addr_i = addr; req_wdata_i = wd;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    chk({tag, " rsp_valid"}, 64'(rsp_valid_o), 64'd1);
    if (exp_lat > 0) chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    e = sb.pop_front();
    chk({tag, " rdata"}, 64'(rsp_rdata_o), 64'(e.rdata));
    chk({tag, " success"}, 64'(rsp_success_o), 64'(e.succ));
    chk({tag, " err"}, 64'(rsp_err_o), 64'(e.err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk({tag, " hold valid"}, 64'(rsp_valid_o), 64'd1);
      chk({tag, " hold req_ready"}, 64'(req_ready_o), 64'd0);
      chk({tag, " hold rdata"}, 64'(rsp_rdata_o), 64'(e.rdata));
      chk({tag, " hold flags"}, 64'({rsp_success_o, rsp_err_o}),
          64'({e.succ, e.err}));
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk({tag, " rsp done"}, 64'({rsp_valid_o, req_ready_o}), 64'b01);
  endtask

  initial begin
    int a0, w0, k;
    repeat (3) @(negedge clk_i);
    chk("reset req_ready", 64'(req_ready_o), 64'd1);
    chk("reset valids", 64'({mst_ar_valid_o, mst_aw_valid_o,
        mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, rsp_valid_o}), 64'd0);
    chk("reset rsp", 64'({rsp_rdata_o, rsp_success_o, rsp_err_o}), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    cfg_rdata = 32'hDEADBEEF; cfg_resp = 2'b01;
    run(1'b0, 32'h100, '0, 3, 0, "lr_exok");
    chk("ar lock", 64'(ar_lock_s), 64'd1);
    chk("ar len", 64'(ar_len_s), 64'd0);
    chk("ar addr", 64'(ar_addr_s), 64'h100);
    chk("ar size", 64'(ar_size_s), 64'd2);
    chk("ar burst", 64'(ar_burst_s), 64'd1);
    chk("ar id", 64'(ar_id_s), 64'(TID));

    cfg_resp = 2'b01;
    run(1'b1, 32'h100, 32'h1234, 3, 0, "sc_exok");
    chk("w strb", 64'(w_strb_s), 64'hF);
    chk("w last", 64'(w_last_s), 64'd1);
    chk("w data", 64'(w_data_s), 64'h1234);
    chk("aw lock", 64'(aw_lock_s), 64'd1);
    chk("aw addr", 64'(aw_addr_s), 64'h100);

    cfg_resp = 2'b00;
    run(1'b1, 32'h104, 32'h55, 3, 0, "sc_okay");
    cfg_rdata = 32'hCAFE0001; cfg_resp = 2'b11;
    run(1'b0, 32'h108, '0, 3, 0, "lr_decerr");

    a0 = aw_cnt; w0 = w_cnt;
    cfg_resp = 2'b01; cfg_aw_delay = 5;
    run(1'b1, 32'h200, 32'hA5A5, 8, 0, "sc_awdly");
    cfg_aw_delay = 0;
    chk("awdly w once", 64'(w_cnt - w0), 64'd1);
    chk("awdly aw once", 64'(aw_cnt - a0), 64'd1);
    chk("awdly aw stable", 64'(aw_unstable), 64'd0);

    cfg_rdata = 32'h0BADF00D; cfg_resp = 2'b10;
    run(1'b0, 32'h10C, '0, 3, 4, "lr_hold");

    r_stall = 1'b1; cfg_rdata = 32'h11112222; cfg_resp = 2'b01;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_sc_i = 1'b0; req_addr_i = 32'h300;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    k = 0;
    while (!mst_r_ready_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("rst in R", 64'(mst_r_ready_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst valids", 64'({mst_ar_valid_o, mst_aw_valid_o,
        mst_w_valid_o, mst_r_ready_o, mst_b_ready_o, rsp_valid_o}), 64'd0);
    chk("rst req_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1; r_stall = 1'b0;
    @(negedge clk_i);
    chk("post rst idle", 64'({req_ready_o, mst_ar_valid_o,
        mst_r_ready_o, rsp_valid_o}), 64'b1000);
    cfg_rdata = 32'h5A5A5A5A; cfg_resp = 2'b01;
    run(1'b0, 32'h300, '0, 3, 0, "lr_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
